// File: rtl/spi_reg_peripheral.sv
// spi_reg_peripheral
//   Write-only SPI (mode 0) target that owns the PWM control register file.
//   Frames are 16 bits, MSB first: {wr, addr[6:0], data[7:0]}. A frame is
//   committed when chip select deasserts, if it is well formed.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   sclk, copi, ncs     SPI pins, asynchronous to clk
//   en_reg_out_7_0      register 0x00
//   en_reg_out_15_8     register 0x01
//   en_reg_pwm_7_0      register 0x02
//   en_reg_pwm_15_8     register 0x03
//   pwm_duty_cycle      register 0x04
//   wr_pulse            one-clk pulse on a committed write
//   frame_err           one-clk pulse on a dropped frame
module spi_reg_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_pulse,
  output logic       frame_err
);

  localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

  typedef enum logic {IDLE, RECV} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_d_q, ncs_d_q;
  logic [SYNC_STAGES:0]   flush_q;
  logic                   ncs_armed_q;

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_fall, ncs_rise;

  logic [15:0] sr_q;
  logic [4:0]  bit_cnt_q;
  logic        do_commit, do_drop;

  logic [7:0] reg0_q, reg1_q, reg2_q, reg3_q, reg4_q;
  logic       wr_pulse_q, frame_err_q;

  // Synchronizers plus one edge-detect flop per pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_d_q    <= 1'b0;
      ncs_d_q     <= 1'b1;
      flush_q     <= '0;
      ncs_armed_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_d_q    <= sclk_s;
      ncs_d_q     <= ncs_s;
      flush_q     <= {flush_q[SYNC_STAGES-1:0], 1'b1};
      if (flush_q[SYNC_STAGES] && ncs_d_q)
        ncs_armed_q <= 1'b1;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];

  // The ncs chain resets high, so if the pin is already low at reset release
  // the flushing chain would fake a falling edge. Falls only count once the
  // edge-detect flop has seen a genuine pin-derived high level.
  assign sclk_rise = sclk_s & ~sclk_d_q;
  assign ncs_fall  = ncs_armed_q & ~ncs_s & ncs_d_q;
  assign ncs_rise  = ncs_s & ~ncs_d_q;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ncs_fall) state_d = RECV;
      RECV:    if (ncs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: commit / drop decision on chip-select release
  always_comb begin
    do_commit = 1'b0;
    do_drop   = 1'b0;
    if (state_q == RECV && ncs_rise) begin
      if (bit_cnt_q == 5'd16 && sr_q[15] && sr_q[14:8] <= MAX_A)
        do_commit = 1'b1;
      else
        do_drop = 1'b1;
    end
  end

  // Shift register, bit counter, register file and pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      reg0_q      <= '0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      reg3_q      <= '0;
      reg4_q      <= '0;
      wr_pulse_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_pulse_q  <= do_commit;
      frame_err_q <= do_drop;

      if (state_q == IDLE && ncs_fall) begin
        sr_q      <= '0;
        bit_cnt_q <= '0;
      end else if (state_q == RECV && !ncs_rise && sclk_rise) begin
        // ncs_rise takes priority: a coincident sclk edge is not shifted
        sr_q <= {sr_q[14:0], copi_s};
        if (bit_cnt_q != 5'd31)
          bit_cnt_q <= bit_cnt_q + 5'd1;
      end

      if (do_commit) begin
        case (sr_q[14:8])
          7'd0:    reg0_q <= sr_q[7:0];
          7'd1:    reg1_q <= sr_q[7:0];
          7'd2:    reg2_q <= sr_q[7:0];
          7'd3:    reg3_q <= sr_q[7:0];
          7'd4:    reg4_q <= sr_q[7:0];
          default: ;
        endcase
      end
    end
  end

  assign en_reg_out_7_0  = reg0_q;
  assign en_reg_out_15_8 = reg1_q;
  assign en_reg_pwm_7_0  = reg2_q;
  assign en_reg_pwm_15_8 = reg3_q;
  assign pwm_duty_cycle  = reg4_q;
  assign wr_pulse        = wr_pulse_q;
  assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// tb_spi_reg_peripheral
//   Directed bench for spi_reg_peripheral: latency of a single write, all
//   addresses, dropped frames, reset mid-frame, back-to-back writes and a
//   run of random frames at the minimum legal sclk timing.
module tb_spi_reg_peripheral;

  localparam int SYNC = 2;
  localparam int HALF = SYNC + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, copi, ncs;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_pulse, frame_err;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int err_cnt  = 0;

  logic [7:0] model [0:4];

  spi_reg_peripheral #(.SYNC_STAGES(SYNC), .MAX_ADDR(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_pulse        (wr_pulse),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_pulse)  wr_cnt  = wr_cnt + 1;
    if (frame_err) err_cnt = err_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] dut_reg(input int a);
    case (a)
      0:       return en_reg_out_7_0;
      1:       return en_reg_out_15_8;
      2:       return en_reg_pwm_7_0;
      3:       return en_reg_pwm_15_8;
      default: return pwm_duty_cycle;
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int a = 0; a < 5; a++)
      check($sformatf("%s_reg%0d", tag, a), {24'h0, dut_reg(a)}, {24'h0, model[a]});
  endtask

  task automatic frame_start();
    ncs = 1'b0;
  endtask

  // copi changes one clk after each sclk fall; sclk high/low held HALF clks
  task automatic frame_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      wait_clk(1);
      copi = bits[i];
      wait_clk(HALF - 1);
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_end(input int gap);
    wait_clk(HALF);
    ncs = 1'b1;
    wait_clk(gap);
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n, input int gap);
    frame_start();
    frame_bits(bits, n);
    frame_end(gap);
  endtask

  initial begin
    int wr0, err0, a;
    logic [7:0] d;
    logic [31:0] drops [0:3];
    int          drop_len [0:3];

    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    wait_clk(3);
    rst = 1'b0;
    check_all("reset");
    check("reset_wr_pulse", {31'h0, wr_pulse}, 32'h0);
    check("reset_frame_err", {31'h0, frame_err}, 32'h0);
    wait_clk(6);

    // Single write to 0x00 with exact latency
    wr0 = wr_cnt;
    frame_start();
    frame_bits(32'h80FF, 16);
    wait_clk(HALF);
    ncs = 1'b1;
    wait_clk(SYNC);
    check("lat_before", {24'h0, en_reg_out_7_0}, 32'h00);
    check("lat_pulse_before", {31'h0, wr_pulse}, 32'h0);
    wait_clk(1);
    check("lat_at", {24'h0, en_reg_out_7_0}, 32'hFF);
    check("lat_pulse_at", {31'h0, wr_pulse}, 32'h1);
    wait_clk(1);
    check("lat_pulse_after", {31'h0, wr_pulse}, 32'h0);
    wait_clk(4);
    model[0] = 8'hFF;
    check_all("single");
    check("single_wr_cnt", wr_cnt - wr0, 1);

    // All five addresses
    wr0 = wr_cnt; err0 = err_cnt;
    send_frame(32'h80A5, 16, 5);
    send_frame(32'h815A, 16, 5);
    send_frame(32'h823C, 16, 5);
    send_frame(32'h83C3, 16, 5);
    send_frame(32'h8480, 16, 5);
    model[0] = 8'hA5; model[1] = 8'h5A; model[2] = 8'h3C; model[3] = 8'hC3; model[4] = 8'h80;
    check_all("alladdr");
    check("alladdr_wr_cnt", wr_cnt - wr0, 5);
    check("alladdr_err_cnt", err_cnt - err0, 0);

    // Dropped frames: read, address 5, 15 bits, 17 bits
    drops[0] = 32'h0400;    drop_len[0] = 16;
    drops[1] = 32'h8512;    drop_len[1] = 16;
    drops[2] = 32'h4011;    drop_len[2] = 15;
    drops[3] = 32'h180FF;   drop_len[3] = 17;
    for (int k = 0; k < 4; k++) begin
      wr0 = wr_cnt; err0 = err_cnt;
      send_frame(drops[k], drop_len[k], 5);
      check($sformatf("drop%0d_err_cnt", k), err_cnt - err0, 1);
      check($sformatf("drop%0d_wr_cnt", k), wr_cnt - wr0, 0);
    end
    check_all("drops");

    // Reset mid-frame, frame continues with ncs low after release
    send_frame(32'h8440, 16, 5);
    model[4] = 8'h40;
    check("pre_rst_duty", {24'h0, pwm_duty_cycle}, 32'h40);
    frame_start();
    frame_bits(32'h84, 8);
    rst = 1'b1;
    #2;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    check_all("rst_async");
    check("rst_wr_pulse", {31'h0, wr_pulse}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    wait_clk(2);
    rst = 1'b0;
    wr0 = wr_cnt; err0 = err_cnt;
    frame_bits(32'h55, 8);
    frame_end(6);
    check("rst_frame_wr_cnt", wr_cnt - wr0, 0);
    check("rst_frame_err_cnt", err_cnt - err0, 0);
    check_all("rst_frame");
    send_frame(32'h847F, 16, 5);
    model[4] = 8'h7F;
    check("post_rst_duty", {24'h0, pwm_duty_cycle}, 32'h7F);

    // Back-to-back writes with the minimum ncs-high gap
    wr0 = wr_cnt;
    send_frame(32'h8211, 16, HALF);
    send_frame(32'h8222, 16, 5);
    model[2] = 8'h22;
    check("b2b_pwm_7_0", {24'h0, en_reg_pwm_7_0}, 32'h22);
    check("b2b_wr_cnt", wr_cnt - wr0, 2);

    // Random frames at minimum sclk timing
    wr0 = wr_cnt; err0 = err_cnt;
    for (int k = 0; k < 100; k++) begin
      a = int'($urandom_range(0, 4));
      d = 8'($urandom);
      send_frame({16'h0, 1'b1, 7'(a), d}, 16, HALF + 1);
      model[a] = d;
      check($sformatf("rand%0d_a%0d", k, a), {24'h0, dut_reg(a)}, {24'h0, d});
    end
    wait_clk(4);
    check_all("rand_final");
    check("rand_wr_cnt", wr_cnt - wr0, 100);
    check("rand_err_cnt", err_cnt - err0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
